mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Control unit for the multicycle MIPS datapath and the driving end of the ALU interface: it produces the 3-bit ALU function code (alucontrol) and consumes the ALU zero flag.
- Moore FSM sequences fetch/decode/execute/memory/writeback over multiple cycles.
- Generates all datapath enables and mux selects.
- Sits beside the datapath; one instance per core.

Parameters:
None. All encodings are constants in the shared package.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset; FSM returns to FETCH
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag, same-cycle combinational
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register load enable
regdst  output  1  write register select: 0=rt, 1=rd
memtoreg  output  1  writeback select: 0=ALUOut, 1=Data
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0=PC, 1=A register
alusrcb  output  2  ALU B select: 00=B reg, 01=const 4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  PC next select: 00=ALUResult, 01=ALUOut, 10=jump target
pcen  output  1  PC load enable
alucontrol  output  3  ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT

Behaviour:
- State register: async reset to FETCH, otherwise updates on rising clk. Every output is a pure function of state, except pcen (also uses zero) and alucontrol (also uses funct).
- Reset values (FETCH outputs): irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0. The datapath is held in reset concurrently, so these values are harmless.
- Internal aluop (2 bits) and per-state outputs; unlisted outputs are 0:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00 → DECODE.
  - DECODE: alusrcb=11, aluop=00. Next state by op: lw/sw(100011/101011)→MEMADR; R-type(000000)→EXECUTE; beq(000100)→BRANCH; addi(001000)→ADDIEX; j(000010)→JUMP; any other op→FETCH (treated as NOP, no writes).
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 → MEMRD if lw, MEMWR if sw.
  - MEMRD: iord=1 → MEMWB.
  - MEMWB: memtoreg=1, regwrite=1 → FETCH.
  - MEMWR: iord=1, memwrite=1 → FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 → ALUWB.
  - ALUWB: regdst=1, regwrite=1 → FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 → FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
  - ADDIWB: regwrite=1 → FETCH.
  - JUMP: pcsrc=10, pcwrite=1 → FETCH.
- pcen = pcwrite | (branch & zero). It is combinational on zero, with no extra latency.
- ALU decoder:
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10 → decode funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Unrecognised funct → 010, with regwrite still asserted in ALUWB.
  - aluop 11 is unused → 010.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- Reset asserted mid-instruction: immediate return to FETCH; any pending writeback is abandoned.
- Illegal state encodings → FETCH.

Optional Feature:
MIPS_CTRL_BNE_EN
- Defined: op 000101 (bne) in DECODE → BRANCH_NE state, with outputs identical to BRANCH but using branch_ne=1; pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
- Undefined: op 000101 is treated as unknown (→ FETCH), and the BRANCH_NE state and its logic are absent.

Decomposition:
- Package mips_ctrl_pkg holds:
  - statetype enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE);
  - funct constants;
  - aluop_t typedef and ALU function-code constants.
- Sub-module alu_decoder is combinational: aluop + funct → alucontrol.
- The FSM (next-state and output logic) stays in the top module.

Test Plan:
- Reset asserted mid-EXECUTE, then released → next cycle state FETCH with irwrite=1, pcen=1, alucontrol=010; no regwrite pulse.
- lw (op 100011) → 5 cycles; alucontrol=010 in FETCH/DECODE/MEMADR; iord=1 in MEMRD; memtoreg=1 and regwrite=1 in cycle 5 only.
- R-type SUB (funct 100010), then SLT (101010) → EXECUTE alucontrol=110 then 111; regdst=1 and regwrite=1 in ALUWB; 4 cycles each.
- beq with zero=1 → BRANCH alucontrol=110, pcsrc=01, pcen=1. With zero=0 → pcen=0. Both return to FETCH after 3 cycles.
- j (000010) → JUMP pcsrc=10, pcen=1. sw → memwrite=1 only in MEMWR. op 111111 → FETCH after DECODE with no memwrite or regwrite.
- Build with MIPS_CTRL_BNE_EN, bne with zero=0 → pcen=1. With zero=1 → pcen=0. Without the macro → bne takes 2 cycles with no pcen in DECODE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU op classes and ALU function codes. Honours MIPS_CTRL_BNE_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALUWB     = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDIEX    = 4'd9,
    S_ADDIWB    = 4'd10,
    S_JUMP      = 4'd11
`ifdef MIPS_CTRL_BNE_EN
    ,S_BRANCH_NE = 4'd12
`endif
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Moore outputs of one FSM state; pcen and alucontrol are derived from these.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
`ifdef MIPS_CTRL_BNE_EN
    logic       branch_ne;
`endif
    aluop_t     aluop;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// enables, mux selects and ALU function code out.
interface mips_multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol
  );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: op class plus funct field -> 3-bit ALU function.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls back to ADD; the writeback still happens.
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Define MIPS_CTRL_BNE_EN to add the bne (BRANCH_NE) path.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_controller_if.master  ctl
);

  statetype state_q, state_d;
  ctrl_t    c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    c       = '0;
    case (state_q)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        case (ctl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH_NE;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        state_d   = (ctl.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.iord  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BRANCH_NE: begin
        c.alusrca   = 1'b1;
        c.aluop     = ALUOP_SUB;
        c.pcsrc     = 2'b01;
        c.branch_ne = 1'b1;
      end
`endif
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ctl.iord     = c.iord;
  assign ctl.memwrite = c.memwrite;
  assign ctl.irwrite  = c.irwrite;
  assign ctl.regdst   = c.regdst;
  assign ctl.memtoreg = c.memtoreg;
  assign ctl.regwrite = c.regwrite;
  assign ctl.alusrca  = c.alusrca;
  assign ctl.alusrcb  = c.alusrcb;
  assign ctl.pcsrc    = c.pcsrc;

  // zero arrives from the ALU in the same cycle the branch resolves.
`ifdef MIPS_CTRL_BNE_EN
  assign ctl.pcen = c.pcwrite | (c.branch & ctl.zero) | (c.branch_ne & ~ctl.zero);
`else
  assign ctl.pcen = c.pcwrite | (c.branch & ctl.zero);
`endif

  alu_decoder u_alu_dec (
    .aluop      (c.aluop),
    .funct      (ctl.funct),
    .alucontrol (ctl.alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench: walks each instruction class cycle by cycle and compares the
// full control word against hand-written per-state values.
module tb_mips_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol}
  logic [14:0] obs;
  assign obs = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
                bus.alucontrol};

  function automatic logic [14:0] w(input logic io, mw, ir, rd, m2r, rw, asa,
                                    input logic [1:0] asb, ps,
                                    input logic pe, input logic [2:0] ac);
    return {io, mw, ir, rd, m2r, rw, asa, asb, ps, pe, ac};
  endfunction

  logic [14:0] W_FETCH, W_DEC, W_MA, W_MRD, W_MWB, W_MWR, W_AWB, W_AIW, W_J;

  function automatic logic [14:0] w_exe(input logic [2:0] ac);
    return w(0,0,0,0,0,0,1, 2'b00, 2'b00, 0, ac);
  endfunction

  function automatic logic [14:0] w_br(input logic pe);
    return w(0,0,0,0,0,0,1, 2'b00, 2'b01, pe, 3'b110);
  endfunction

  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    n_chk++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, o, e);
    end
  endtask

  // Called just after a negedge: check current state, then advance one cycle.
  task automatic step(input string tag, input logic [14:0] e);
    #1 chk(tag, obs, e);
    @(negedge clk);
  endtask

  logic [5:0] fn_tab [6] = '{6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b100000, 6'b111111};
  logic [2:0] ac_tab [6] = '{3'b110,   3'b111,   3'b000,   3'b001,   3'b010,   3'b010};

  initial begin
    W_FETCH = w(0,0,1,0,0,0,0, 2'b01, 2'b00, 1, 3'b010);
    W_DEC   = w(0,0,0,0,0,0,0, 2'b11, 2'b00, 0, 3'b010);
    W_MA    = w(0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 3'b010);
    W_MRD   = w(1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 3'b010);
    W_MWB   = w(0,0,0,0,1,1,0, 2'b00, 2'b00, 0, 3'b010);
    W_MWR   = w(1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 3'b010);
    W_AWB   = w(0,0,0,1,0,1,0, 2'b00, 2'b00, 0, 3'b010);
    W_AIW   = w(0,0,0,0,0,1,0, 2'b00, 2'b00, 0, 3'b010);
    W_J     = w(0,0,0,0,0,0,0, 2'b00, 2'b10, 1, 3'b010);

    reset = 1'b0; bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    #1 chk("rst_hold", obs, W_FETCH);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of EXECUTE abandons the R-type writeback.
    bus.op = 6'b000000; bus.funct = 6'b100000;
    step("rx_fetch", W_FETCH);
    step("rx_dec",   W_DEC);
    #1 chk("rx_exe", obs, w_exe(3'b010));
    reset = 1'b1;
    #1 chk("rx_async", obs, W_FETCH);
    @(negedge clk);
    reset = 1'b0;

    // lw: 5 cycles
    bus.op = 6'b100011;
    step("lw_fetch", W_FETCH);
    step("lw_dec",   W_DEC);
    step("lw_madr",  W_MA);
    step("lw_mrd",   W_MRD);
    step("lw_mwb",   W_MWB);

    // sw: 4 cycles
    bus.op = 6'b101011;
    step("sw_fetch", W_FETCH);
    step("sw_dec",   W_DEC);
    step("sw_madr",  W_MA);
    step("sw_mwr",   W_MWR);

    // R-type: 4 cycles each, funct sweep including an unknown code
    bus.op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      bus.funct = fn_tab[i];
      step($sformatf("r%0d_fetch", i), W_FETCH);
      step($sformatf("r%0d_dec", i),   W_DEC);
      step($sformatf("r%0d_exe", i),   w_exe(ac_tab[i]));
      step($sformatf("r%0d_wb", i),    W_AWB);
    end
    bus.funct = 6'b000000;

    // addi: 4 cycles
    bus.op = 6'b001000;
    step("addi_fetch", W_FETCH);
    step("addi_dec",   W_DEC);
    step("addi_ex",    W_MA);
    step("addi_wb",    W_AIW);

    // beq taken, then zero dropped within the same cycle
    bus.op = 6'b000100; bus.zero = 1'b1;
    step("beq1_fetch", W_FETCH);
    step("beq1_dec",   W_DEC);
    #1 chk("beq1_br_z1", obs, w_br(1'b1));
    bus.zero = 1'b0;
    #1 chk("beq1_br_z0", obs, w_br(1'b0));
    @(negedge clk);

    // beq not taken
    step("beq0_fetch", W_FETCH);
    step("beq0_dec",   W_DEC);
    step("beq0_br",    w_br(1'b0));

    // j: 3 cycles
    bus.op = 6'b000010;
    step("j_fetch", W_FETCH);
    step("j_dec",   W_DEC);
    step("j_jump",  W_J);

    // unknown op: 2 cycles, no writes
    bus.op = 6'b111111;
    step("nop_fetch", W_FETCH);
    step("nop_dec",   W_DEC);

    // bne
    bus.op = 6'b000101; bus.zero = 1'b0;
    step("bne_fetch", W_FETCH);
    step("bne_dec",   W_DEC);
`ifdef MIPS_CTRL_BNE_EN
    #1 chk("bne_br_z0", obs, w_br(1'b1));
    bus.zero = 1'b1;
    #1 chk("bne_br_z1", obs, w_br(1'b0));
    @(negedge clk);
    bus.zero = 1'b0;
`endif

    bus.op = 6'b111111;
    step("end_fetch", W_FETCH);
    step("end_dec",   W_DEC);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
